// File: rtl/te_block_serializer_if.sv
// Purpose: bundles the multi-lane trace-block input group, the single-block
//          encoder stream (valid/ready) and the overflow status/clear signals.
// Ports  : slave modport is the serializer view, master modport is the
//          retirement-stage + encoder view (the testbench drives it).
interface te_block_serializer_if #(
  parameter int N           = 1,
  parameter int DEPTH       = 16,
  parameter int DROP_CNT_W  = 16,
  parameter int XLEN        = 32,
  parameter int IRETIRE_LEN = 8,
  parameter int ITYPE_LEN   = 4,
  parameter int CAUSE_LEN   = 6,
  parameter int PRIV_LEN    = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Upstream group (no backpressure towards the retirement stage)
  logic [N-1:0]             valid_i;
  logic [N*IRETIRE_LEN-1:0] iretire_i;
  logic [N-1:0]             ilastsize_i;
  logic [N*ITYPE_LEN-1:0]   itype_i;
  logic [N*XLEN-1:0]        iaddr_i;
  logic [CAUSE_LEN-1:0]     cause_i;
  logic [XLEN-1:0]          tval_i;
  logic [PRIV_LEN-1:0]      priv_i;

  // Downstream single-block stream
  logic                     valid_o;
  logic                     ready_i;
  logic [IRETIRE_LEN-1:0]   iretire_o;
  logic                     ilastsize_o;
  logic [ITYPE_LEN-1:0]     itype_o;
  logic [XLEN-1:0]          iaddr_o;
  logic [CAUSE_LEN-1:0]     cause_o;
  logic [XLEN-1:0]          tval_o;
  logic [PRIV_LEN-1:0]      priv_o;

  // Status
  logic [CNT_W-1:0]         usage_o;
  logic                     overflow_o;
  logic [DROP_CNT_W-1:0]    drop_cnt_o;
  logic                     clear_ovf_i;

  modport slave (
    input  valid_i, iretire_i, ilastsize_i, itype_i, iaddr_i, cause_i, tval_i, priv_i,
    input  ready_i, clear_ovf_i,
    output valid_o, iretire_o, ilastsize_o, itype_o, iaddr_o, cause_o, tval_o, priv_o,
    output usage_o, overflow_o, drop_cnt_o
  );

  modport master (
    output valid_i, iretire_i, ilastsize_i, itype_i, iaddr_i, cause_i, tval_i, priv_i,
    output ready_i, clear_ovf_i,
    input  valid_o, iretire_o, ilastsize_o, itype_o, iaddr_o, cause_o, tval_o, priv_o,
    input  usage_o, overflow_o, drop_cnt_o
  );
endinterface

// File: rtl/te_block_serializer.sv
// Purpose     : packs up to N trace blocks per cycle into a circular FIFO and
//               hands them one per cycle to the trace encoder.
// Latency     : 1 cycle push-to-output (0 with TE_SERIALIZER_BYPASS_EN and an empty FIFO).
// Backpressure: ready_i stalls the output stream; upstream cannot be stalled, so a
//               group that does not fit is dropped whole and counted.
// Ports: clk_i/rst_i (sync, active-high) plus one te_block_serializer_if.slave
//        carrying the input lanes, output block stream, usage and overflow status.
// Optional macro TE_SERIALIZER_BYPASS_EN: single block into an empty FIFO with
//        ready_i high is forwarded combinationally instead of being stored.
module te_block_serializer #(
  parameter int N           = 1,
  parameter int DEPTH       = 16,
  parameter int DROP_CNT_W  = 16,
  parameter int XLEN        = 32,
  parameter int IRETIRE_LEN = 8,
  parameter int ITYPE_LEN   = 4,
  parameter int CAUSE_LEN   = 6,
  parameter int PRIV_LEN    = 2
) (
  input logic                   clk_i,
  input logic                   rst_i,
  te_block_serializer_if.slave  ser_if
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [XLEN-1:0]        iaddr;
    logic [PRIV_LEN-1:0]    priv;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
  } entry_t;

  entry_t                mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  entry_t                lane_ent [N];
  logic [PTR_W-1:0]      lane_idx [N];
  logic [CNT_W-1:0]      k;
  logic [CNT_W-1:0]      free;
  logic [CNT_W-1:0]      admit_k;
  logic                  fifo_vld;
  logic                  pop;
  logic                  bypass;
  logic                  wr_en;
  logic                  drop;
  entry_t                out_ent;
  logic                  out_vld;

  // Build each lane's entry and its compacted slot. k holds the number of valid
  // lanes below the current one while iterating, so it doubles as the slot offset.
  always_comb begin
    k = '0;
    for (int l = 0; l < N; l++) begin
      logic [ITYPE_LEN-1:0] it;
      logic                 exc;
      it  = ser_if.itype_i[l*ITYPE_LEN +: ITYPE_LEN];
      // Only lane 0 can carry an exception/interrupt; everyone else stores zeros.
      exc = (l == 0) && ((it == ITYPE_LEN'(1)) || (it == ITYPE_LEN'(2)));
      lane_ent[l].iretire   = ser_if.iretire_i[l*IRETIRE_LEN +: IRETIRE_LEN];
      lane_ent[l].ilastsize = ser_if.ilastsize_i[l];
      lane_ent[l].itype     = it;
      lane_ent[l].iaddr     = ser_if.iaddr_i[l*XLEN +: XLEN];
      lane_ent[l].priv      = ser_if.priv_i;
      lane_ent[l].cause     = exc ? ser_if.cause_i : '0;
      lane_ent[l].tval      = exc ? ser_if.tval_i  : '0;
      lane_idx[l]           = wr_ptr_q + k[PTR_W-1:0];
      if (ser_if.valid_i[l]) k = k + CNT_W'(1);
    end
  end

  assign fifo_vld = (count_q != '0);
  assign pop      = fifo_vld && ser_if.ready_i;
  // A pop in this cycle frees a slot for the incoming group.
  assign free     = CNT_W'(DEPTH) - count_q + CNT_W'(pop);

`ifdef TE_SERIALIZER_BYPASS_EN
  assign bypass = !fifo_vld && (k == CNT_W'(1)) && ser_if.ready_i;
`else
  assign bypass = 1'b0;
`endif

  assign wr_en   = !bypass && (k != '0) && (k <= free);
  assign drop    = !bypass && (k > free);
  assign admit_k = wr_en ? k : '0;

  always_comb begin
    wr_ptr_d   = wr_en ? (wr_ptr_q + k[PTR_W-1:0]) : wr_ptr_q;
    rd_ptr_d   = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d    = count_q + admit_k - CNT_W'(pop);
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    // Drop beats clear so a loss in the clearing cycle is never hidden.
    if (drop) begin
      overflow_d = 1'b1;
      if (ser_if.clear_ovf_i)  drop_cnt_d = DROP_CNT_W'(1);
      else if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end else if (ser_if.clear_ovf_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: contents are only visible while count_q says so.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int l = 0; l < N; l++) begin
        if (ser_if.valid_i[l]) mem_q[lane_idx[l]] <= lane_ent[l];
      end
    end
  end

  // Output is the head entry, forced to zero when empty so idle fields are clean.
  always_comb begin
    out_ent = '0;
    out_vld = 1'b0;
    if (fifo_vld) begin
      out_ent = mem_q[rd_ptr_q];
      out_vld = 1'b1;
    end else if (bypass) begin
      for (int l = 0; l < N; l++) begin
        if (ser_if.valid_i[l]) out_ent = lane_ent[l];
      end
      out_vld = 1'b1;
    end
  end

  assign ser_if.valid_o     = out_vld;
  assign ser_if.iretire_o   = out_ent.iretire;
  assign ser_if.ilastsize_o = out_ent.ilastsize;
  assign ser_if.itype_o     = out_ent.itype;
  assign ser_if.iaddr_o     = out_ent.iaddr;
  assign ser_if.cause_o     = out_ent.cause;
  assign ser_if.tval_o      = out_ent.tval;
  assign ser_if.priv_o      = out_ent.priv;
  assign ser_if.usage_o     = count_q;
  assign ser_if.overflow_o  = overflow_q;
  assign ser_if.drop_cnt_o  = drop_cnt_q;

endmodule
